// File: rtl/aes_pkg.sv
// AES-128 shared definitions: FSM states, round constants, S-boxes and round transforms.
// Byte n of a 128-bit block sits at bits [8n+7:8n], byte n = row (n%4), column (n/4).
package aes_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned NR    = 10;
  localparam int unsigned EK_W  = BLK_W * (NR + 1);
  localparam int unsigned RND_W = 4;

  typedef enum logic [2:0] {LOAD, KEYEXP, ENC, DEC, DONE} aes_state_e;

  // Indexed directly by round number; entry 0 and 11..15 are unused.
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Entry 0 is the most significant byte of each table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return INV_SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{m[0]}} & a) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    return {inv_sub_word(s[127:96]), inv_sub_word(s[95:64]),
            inv_sub_word(s[63:32]), inv_sub_word(s[31:0])};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[11], b[6], b[1], b[12], b[7], b[2], b[13], b[8],
            b[3], b[14], b[9], b[4], b[15], b[10], b[5], b[0]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[3], b[6], b[9], b[12], b[15], b[2], b[5], b[8],
            b[11], b[14], b[1], b[4], b[7], b[10], b[13], b[0]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [3:0][7:0] a;
    a = w;
    return {gmul(a[0], 4'd3) ^ a[1] ^ a[2] ^ gmul(a[3], 4'd2),
            a[0] ^ a[1] ^ gmul(a[2], 4'd2) ^ gmul(a[3], 4'd3),
            a[0] ^ gmul(a[1], 4'd2) ^ gmul(a[2], 4'd3) ^ a[3],
            gmul(a[0], 4'd2) ^ gmul(a[1], 4'd3) ^ a[2] ^ a[3]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [3:0][7:0] a;
    a = w;
    return {gmul(a[0], 4'd11) ^ gmul(a[1], 4'd13) ^ gmul(a[2], 4'd9) ^ gmul(a[3], 4'd14),
            gmul(a[0], 4'd13) ^ gmul(a[1], 4'd9) ^ gmul(a[2], 4'd14) ^ gmul(a[3], 4'd11),
            gmul(a[0], 4'd9) ^ gmul(a[1], 4'd14) ^ gmul(a[2], 4'd11) ^ gmul(a[3], 4'd13),
            gmul(a[0], 4'd14) ^ gmul(a[1], 4'd11) ^ gmul(a[2], 4'd13) ^ gmul(a[3], 4'd9)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives round key rnd from round key rnd-1.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] prev_key,
  input  logic [RND_W-1:0] rnd,
  output logic [BLK_W-1:0] next_key_c
);

  logic [3:0][31:0] w;
  logic [3:0][31:0] n;
  logic [31:0]      temp;

  always_comb begin
    w       = prev_key;
    // RotWord moves byte 0 (low bits) to byte 3 before SubWord.
    temp    = sub_word({w[3][7:0], w[3][31:8]}) ^ {24'h000000, RCON[rnd]};
    n[0]    = w[0] ^ temp;
    n[1]    = w[1] ^ n[0];
    n[2]    = w[2] ^ n[1];
    n[3]    = w[3] ^ n[2];
    next_key_c = n;
  end

endmodule

// File: rtl/aes_top.sv
// Free-running AES-128 engine: key expansion, encryption, then decryption of the result,
// one round per clock; restarts whenever key or plain_text differ from the captured copy.
module aes_top
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] key,
  input  logic [BLK_W-1:0] plain_text,
  output logic [EK_W-1:0]  expanded_key,
  output logic [BLK_W-1:0] cypher_text,
  output logic [BLK_W-1:0] decrypted_plain_text
);

  localparam int unsigned WORK_W = EK_W - BLK_W;

  aes_state_e        fsm_q, fsm_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [BLK_W-1:0]  k_q, k_d, p_q, p_d, st_q, st_d;
  logic [BLK_W-1:0]  ct_q, ct_d, pt_q, pt_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [EK_W-1:0]   ek_q, ek_d;

  logic [BLK_W-1:0]  next_key_c, rk_cur_c, enc_sr_c, enc_out_c, dec_ark_c, dec_out_c;

  // Newest round key lives at the top of the work buffer, rk0 ends at the bottom.
  aes_key_step u_key_step (
    .prev_key   (work_q[WORK_W-1 -: BLK_W]),
    .rnd        (rnd_q),
    .next_key_c (next_key_c)
  );

  always_comb begin
    rk_cur_c  = ek_q[{rnd_q, 7'd0} +: BLK_W];
    enc_sr_c  = shift_rows(sub_bytes(st_q));
    enc_out_c = ((rnd_q == RND_W'(NR)) ? enc_sr_c : mix_cols(enc_sr_c)) ^ rk_cur_c;
    dec_ark_c = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_cur_c;
    dec_out_c = (rnd_q == '0) ? dec_ark_c : inv_mix_cols(dec_ark_c);
  end

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    k_d    = k_q;
    p_d    = p_q;
    st_d   = st_q;
    work_d = work_q;
    ek_d   = ek_q;
    ct_d   = ct_q;
    pt_d   = pt_q;
    case (fsm_q)
      LOAD: begin
        k_d    = key;
        p_d    = plain_text;
        st_d   = plain_text ^ key;
        work_d = {key, work_q[WORK_W-1:BLK_W]};
        rnd_d  = RND_W'(1);
        fsm_d  = KEYEXP;
      end
      KEYEXP: begin
        work_d = {next_key_c, work_q[WORK_W-1:BLK_W]};
        if (rnd_q == RND_W'(NR)) begin
          ek_d  = {next_key_c, work_q};
          rnd_d = RND_W'(1);
          fsm_d = ENC;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      ENC: begin
        st_d = enc_out_c;
        if (rnd_q == RND_W'(NR)) begin
          // Decryption opens with AddRoundKey(rk10) on the fresh ciphertext.
          ct_d  = enc_out_c;
          st_d  = enc_out_c ^ ek_q[EK_W-1 -: BLK_W];
          rnd_d = RND_W'(NR - 1);
          fsm_d = DEC;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      DEC: begin
        st_d = dec_out_c;
        if (rnd_q == '0) begin
          pt_d  = dec_out_c;
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q - RND_W'(1);
        end
      end
      DONE: begin
        if ((key != k_q) || (plain_text != p_q)) fsm_d = LOAD;
      end
      default: fsm_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= LOAD;
      rnd_q  <= '0;
      k_q    <= '0;
      p_q    <= '0;
      st_q   <= '0;
      work_q <= '0;
      ek_q   <= '0;
      ct_q   <= '0;
      pt_q   <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      k_q    <= k_d;
      p_q    <= p_d;
      st_q   <= st_d;
      work_q <= work_d;
      ek_q   <= ek_d;
      ct_q   <= ct_d;
      pt_q   <= pt_d;
    end
  end

  assign expanded_key         = ek_q;
  assign cypher_text          = ct_q;
  assign decrypted_plain_text = pt_q;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top against a byte-level AES-128 model whose S-box is
// derived from GF(2^8) inversion and the affine map.
module tb_aes_top;

  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] K3 = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] P3 = 128'h54494D47206E616C6F4E20726F6E6F43;

  logic          clk, rst;
  logic [127:0]  key, plain_text;
  logic [1407:0] expanded_key;
  logic [127:0]  cypher_text, decrypted_plain_text;

  int            checks, errors;
  logic [1407:0] exp_ek;
  logic [127:0]  exp_ct, exp_pt;
  logic [7:0]    sb_m [256];

  aes_top dut (
    .clk                  (clk),
    .rst                  (rst),
    .key                  (key),
    .plain_text           (plain_text),
    .expanded_key         (expanded_key),
    .cypher_text          (cypher_text),
    .decrypted_plain_text (decrypted_plain_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? (8'(a << 1) ^ 8'h1b) : 8'(a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int k);
    return 8'({b, b} >> (8 - k));
  endfunction

  function automatic logic [7:0] gb(logic [127:0] v, int n);
    return 8'(v >> (8 * n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k, output logic [1407:0] ek);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = gb(k, 4 * i + j);
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) t[j] = sb_m[w[i-1][(j + 1) % 4]];
        t[0] = t[0] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    ek = '0;
    for (int i = 0; i < 44; i++)
      for (int j = 0; j < 4; j++) ek = ek | (1408'(w[i][j]) << (8 * (4 * i + j)));
  endtask

  function automatic logic [127:0] model_encrypt(logic [127:0] pt, logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   v [16];
    logic [127:0] rk, res;
    int           d;
    logic [7:0]   acc;
    rk = 128'(ek);
    for (int n = 0; n < 16; n++) s[n] = gb(pt, n) ^ gb(rk, n);
    for (int r = 1; r <= 10; r++) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) v[row + 4 * c] = sb_m[s[row + 4 * ((c + row) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int kk = 0; kk < 4; kk++) begin
              d = (kk - row + 4) % 4;
              acc = acc ^ gf_mul((d == 0) ? 8'h02 : ((d == 1) ? 8'h03 : 8'h01), v[kk + 4 * c]);
            end
            s[row + 4 * c] = acc;
          end
      end else begin
        s = v;
      end
      rk = 128'(ek >> (128 * r));
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ gb(rk, n);
    end
    res = '0;
    for (int n = 0; n < 16; n++) res = res | (128'(s[n]) << (8 * n));
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ek(input string tag, input logic [1407:0] e);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s_rk%0d", tag, r), 128'(expanded_key >> (128 * r)), 128'(e >> (128 * r)));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after an edge while the engine sits in DONE.
  task automatic restart(input logic [127:0] nk, input logic [127:0] np);
    logic [1407:0] nek;
    logic [127:0]  nct;
    model_expand(nk, nek);
    nct = model_encrypt(np, nek);
    key = nk;
    plain_text = np;
    step(11);
    chk_ek("rs_ek_hold", exp_ek);
    chk("rs_ct_hold_early", cypher_text, exp_ct);
    step(1);
    chk_ek("rs_ek_new", nek);
    step(9);
    chk("rs_ct_hold", cypher_text, exp_ct);
    step(1);
    chk("rs_ct_new", cypher_text, nct);
    step(9);
    chk("rs_pt_hold", decrypted_plain_text, exp_pt);
    step(1);
    chk("rs_pt_new", decrypted_plain_text, np);
    exp_ek = nek;
    exp_ct = nct;
    exp_pt = np;
  endtask

  initial begin
    logic [127:0] rk_tmp, rp_tmp;
    checks = 0;
    errors = 0;
    build_sbox();

    rst = 1'b0;
    key = K1;
    plain_text = P1;
    #12;
    chk_ek("rst_ek", '0);
    chk("rst_ct", cypher_text, '0);
    chk("rst_pt", decrypted_plain_text, '0);

    rst = 1'b1;
    model_expand(K1, exp_ek);
    exp_ct = model_encrypt(P1, exp_ek);
    exp_pt = P1;
    step(10);
    chk_ek("ek_c10_zero", '0);
    step(1);
    chk_ek("ek_c11", exp_ek);
    chk("ek_rk10_k1", expanded_key[1407:1280], 128'hc5302b4d8ba707f3174a94e37f1d1113);
    chk("ek_rk0_k1", expanded_key[127:0], K1);
    chk("ct_c11_zero", cypher_text, '0);
    step(9);
    chk("ct_c20_zero", cypher_text, '0);
    step(1);
    chk("ct_c21_fips", cypher_text, 128'h5ac5b47080b7cdd830047b6ad8e0c469);
    chk("ct_c21_model", cypher_text, exp_ct);
    step(9);
    chk("pt_c30_zero", decrypted_plain_text, '0);
    step(1);
    chk("pt_c31", decrypted_plain_text, P1);
    step(3);
    chk("done_ct_hold", cypher_text, exp_ct);
    chk("done_pt_hold", decrypted_plain_text, P1);

    restart(K1, {$urandom, $urandom, $urandom, $urandom});
    restart(K2, {$urandom, $urandom, $urandom, $urandom});
    chk("ek_rk10_k2", expanded_key[1407:1280], 128'ha60c63b6c80c3fe18925eec9a8f914d0);
    restart(K3, P3);
    for (int i = 0; i < 4; i++)
      restart({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

    // Abort a fresh computation at its cycle 15 with reset.
    rk_tmp = {$urandom, $urandom, $urandom, $urandom};
    rp_tmp = {$urandom, $urandom, $urandom, $urandom};
    key = rk_tmp;
    plain_text = rp_tmp;
    step(16);
    rst = 1'b0;
    #1;
    chk_ek("rst15_ek", '0);
    chk("rst15_ct", cypher_text, '0);
    chk("rst15_pt", decrypted_plain_text, '0);
    key = K1;
    plain_text = P1;
    step(1);
    chk("rst15_ct_held", cypher_text, '0);
    rst = 1'b1;
    model_expand(K1, exp_ek);
    exp_ct = model_encrypt(P1, exp_ek);
    step(10);
    chk_ek("post_rst_ek_c10", '0);
    step(1);
    chk_ek("post_rst_ek_c11", exp_ek);
    step(9);
    chk("post_rst_ct_c20", cypher_text, '0);
    step(1);
    chk("post_rst_ct_c21", cypher_text, 128'h5ac5b47080b7cdd830047b6ad8e0c469);
    step(9);
    chk("post_rst_pt_c30", decrypted_plain_text, '0);
    step(1);
    chk("post_rst_pt_c31", decrypted_plain_text, P1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_top.md
# aes_top

AES-128 encrypt-then-decrypt engine. From a 128-bit key and plaintext it produces the full key schedule, the ciphertext, and the round-trip decryption of that ciphertext, as a self-checking crypto core. It free-runs from reset with no start handshake: inputs are sampled, processed iteratively one round per clock, and the outputs are held until an input changes.

## Interface
- No parameters (AES-128 fixed: Nk=4, Nr=10).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key  in  128  cipher key; byte i = bits [8i+7:8i], byte 0 = first FIPS-197 key byte.
- plain_text  in  128  plaintext; same byte order as key.
- expanded_key  out  1408  11 round keys; round key r at bits [128r+127:128r], each in the same byte order.
- cypher_text  out  128  AES-128 encryption of the sampled plain_text.
- decrypted_plain_text  out  128  AES-128 decryption of cypher_text; equals the sampled plain_text.

## Operation
- States: LOAD, KEYEXP, ENC, DEC, DONE.
- LOAD (1 cycle):
  - Capture key and plain_text into registers k_q and p_q.
  - Round key 0 = key.
  - state <= plain_text ^ key.
- KEYEXP (10 cycles, rnd 1..10): round key rnd from round key rnd-1 via RotWord, SubWord and Rcon[rnd]. Rcon = 01,02,04,08,10,20,40,80,1b,36.
- ENC (10 cycles, rnd 1..10):
  - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk[rnd]).
  - Round 10: omits MixColumns.
  - On exit: cypher_text <= state; state <= state ^ rk[10].
- DEC (10 cycles, rnd 9 down to 0):
  - InvShiftRows, InvSubBytes, AddRoundKey(rk[rnd]), then InvMixColumns except on rnd 0.
  - On exit: decrypted_plain_text <= state.
- DONE: holds all outputs. If key != k_q or plain_text != p_q, go to LOAD next cycle.
- Input changes during KEYEXP, ENC or DEC are ignored until DONE.
- GF(2^8) arithmetic uses polynomial 0x11b (xtime: shift left, XOR 0x1b if bit 7 was set).

## Timing
- Reset (rst low, asynchronous):
  - All outputs and internal registers = 0.
  - FSM = LOAD, rnd = 0.
- Cycle numbering: cycle 1 is the first rising edge with rst high.
  - expanded_key is updated as a whole at the end of cycle 11. It is not exposed partially.
  - cypher_text valid after cycle 21.
  - decrypted_plain_text valid after cycle 31; DONE is entered at edge 31.
- Outputs from a previous computation hold until overwritten by the new one. There is no transient garbage.
- After an input change, the restart latency is 31 cycles plus 1 detection cycle.
- Reset mid-operation aborts at once. After release, the sequence restarts from LOAD.

## Structure
- Package aes_pkg:
  - SBOX and INV_SBOX as 256-entry constant functions.
  - RCON array.
  - Functions: xtime, mix_col, inv_mix_col, shift_rows, inv_shift_rows, sub_word.
  - FSM state enum.
- One sub-module, aes_key_step: combinational, takes round key r-1 and rnd, returns round key r.
- Datapath round logic lives in aes_top using the package functions.

## Test plan
- Reset held low: all outputs 0. Release with key = 128'h0f0e0d0c0b0a09080706050403020100 and plain_text = 128'hffeeddccbbaa99887766554433221100:
  - After cycle 21: cypher_text = 128'h5ac5b47080b7cdd830047b6ad8e0c469.
  - After cycle 31: decrypted_plain_text equals plain_text.
- Same key, key schedule check after cycle 11:
  - expanded_key[1407:1280] = 128'hc5302b4d8ba707f3174a94e37f1d1113.
  - expanded_key[127:0] = key.
- key = 128'h3c4fcf098815f7aba6d2ae2816157e2b: expanded_key[1407:1280] = 128'ha60c63b6c80c3fe18925eec9a8f914d0.
- key = 128'h100F0E0D0C0B0A090807060504030201, plain_text = 128'h54494D47206E616C6F4E20726F6E6F43: decrypted_plain_text equals plain_text after cycle 31; cypher_text is checked against a software model.
- Change plain_text while in DONE: old outputs hold, then new cypher_text appears 22 cycles after the change.
- Assert reset at cycle 15: all outputs go to 0 immediately. After release, the first vector completes at the nominal cycle counts.
